// File: rtl/case_2_prod_accum.sv
// ---------------------------------------------------------------------------
// case_2_prod_accum
//
// Sums a job of `len` signed products from the 4-bit signed multiplier stage
// into a saturating accumulator. The result is then offered downstream on a
// valid/ready interface. A one-shot `start` pulse, sampled only while idle,
// begins each job.
//
// Ports:
//   ap_clk    : clock; all state changes on the rising edge
//   ap_rst    : asynchronous, active-high reset
//   start     : begin a job (sampled only in IDLE)
//   len       : unsigned product count, latched when start is accepted
//   prod_din  : signed product from the multiplier
//   prod_vld  : prod_din is valid
//   prod_rdy  : block accepts prod_din this cycle
//   acc_dout  : signed accumulated (saturated) result
//   acc_vld   : acc_dout is valid
//   acc_rdy   : downstream accepts acc_dout
//   busy      : high whenever the block is not idle
//   ovf       : sticky saturation flag for the current/last job
// ---------------------------------------------------------------------------
module case_2_prod_accum #(
  parameter int PROD_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [PROD_WIDTH-1:0] prod_din,
  input  logic                  prod_vld,
  output logic                  prod_rdy,
  output logic [ACC_WIDTH-1:0]  acc_dout,
  output logic                  acc_vld,
  input  logic                  acc_rdy,
  output logic                  busy,
  output logic                  ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturation rails in two's complement.
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   acc_dout_q, acc_dout_d;
  logic                   ovf_q, ovf_d;

  logic                   beat;
  logic [ACC_WIDTH:0]     acc_ext;
  logic [ACC_WIDTH:0]     prod_ext;
  logic [ACC_WIDTH:0]     sum_full;
  logic                   sat_hit;
  logic [ACC_WIDTH-1:0]   sat_val;

  // The add is done one bit wider than the accumulator. Overflow shows up
  // as a disagreement between the two top bits, and the extra sign bit
  // selects which rail to clamp to.
  always_comb begin
    acc_ext  = {acc_q[ACC_WIDTH-1], acc_q};
    prod_ext = {{(ACC_WIDTH+1-PROD_WIDTH){prod_din[PROD_WIDTH-1]}}, prod_din};
    sum_full = acc_ext + prod_ext;
    sat_hit  = sum_full[ACC_WIDTH] ^ sum_full[ACC_WIDTH-1];
    if (sat_hit) begin
      sat_val = sum_full[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_val = sum_full[ACC_WIDTH-1:0];
    end
  end

  // Handshake outputs are pure decodes of the registered state. They are
  // therefore glitch-free, and they are zero while reset is applied.
  always_comb begin
    prod_rdy = (state_q == ACC);
    acc_vld  = (state_q == DONE);
    busy     = (state_q != IDLE);
    beat     = prod_vld & prod_rdy;
    acc_dout = acc_dout_q;
    ovf      = ovf_q;
  end

  // Next-state logic for the job sequencer.
  // The DONE state only watches the output handshake. A start pulse that
  // arrives in the same cycle as the handshake is therefore dropped.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    acc_dout_d = acc_dout_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d      = len;
          acc_d      = '0;
          ovf_d      = 1'b0;
          acc_dout_d = '0;
          state_d    = (len != '0) ? ACC : DONE;
        end
      end

      ACC: begin
        if (beat) begin
          acc_d = sat_val;
          ovf_d = ovf_q | sat_hit;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            acc_dout_d = sat_val;
            state_d    = DONE;
          end
        end
      end

      DONE: begin
        if (acc_rdy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset aborts any job in flight immediately, so no
  // partial result ever appears on the output.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      acc_dout_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      acc_dout_q <= acc_dout_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
